// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for the branch resolver and condition evaluator.
package branch_pkg;
  localparam int BR_W = 8;
  typedef enum logic [1:0] {BEQ = 2'd0, BNE = 2'd1, BLT = 2'd2, BGE = 2'd3} br_op_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} br_state_t;
endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: combinational branch condition evaluation from sign/zero flags.
module br_cond_eval
  import branch_pkg::*;
(
  input  br_op_t op,
  input  logic   sign,
  input  logic   z,
  output logic   taken
);
  assign taken = op == BEQ ? z : op == BNE ? !z : op == BLT ? sign : !sign;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: condition-code register and branch resolver with registered result.
// Define BRANCH_STATS_EN to add saturating taken/not-taken counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int W = BR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmp_issue,
  input  logic         flag_we,
  input  logic         sign_in,
  input  logic         z_in,
  input  logic         br_valid,
  output logic         br_ready,
  input  logic [1:0]   br_op,
  input  logic [W-1:0] br_pc,
  input  logic [W-1:0] br_off,
  output logic         res_valid,
  output logic         res_taken,
  output logic [W-1:0] res_target
`ifdef BRANCH_STATS_EN
  ,
  output logic [7:0]   stat_taken,
  output logic [7:0]   stat_not_taken
`endif
);
  br_state_t state, state_nxt;
  br_op_t op_q, op_e;
  logic f_sign, f_z, pending;
  logic [W-1:0] pc_q, off_q, pc_e, off_e;
  logic idle, go, sign_e, z_e, taken;
  // Resolution happens on the transition into RESOLVE, so the result registers
  // present a stable value for the whole RESOLVE cycle; incoming flags bypass stored ones.
  always_comb begin
    idle = state == IDLE;
    sign_e = flag_we ? sign_in : f_sign;
    z_e = flag_we ? z_in : f_z;
    op_e = idle ? br_op_t'(br_op) : op_q;
    pc_e = idle ? br_pc : pc_q;
    off_e = idle ? br_off : off_q;
    go = idle ? br_valid && (!pending || flag_we) : state == WAIT && flag_we;
    state_nxt = go ? RESOLVE : (idle && br_valid) || state == WAIT ? WAIT : IDLE;
    br_ready = idle;
  end
  br_cond_eval u_eval (.op(op_e), .sign(sign_e), .z(z_e), .taken(taken));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      f_sign <= 1'b0;
      f_z <= 1'b0;
      pending <= 1'b0;
      op_q <= BEQ;
      pc_q <= '0;
      off_q <= '0;
      res_valid <= 1'b0;
      res_taken <= 1'b0;
      res_target <= '0;
    end else begin
      state <= state_nxt;
      pending <= cmp_issue || (pending && !flag_we);
      if (flag_we) begin
        f_sign <= sign_in;
        f_z <= z_in;
      end
      if (idle && br_valid) begin
        op_q <= br_op_t'(br_op);
        pc_q <= br_pc;
        off_q <= br_off;
      end
      res_valid <= go;
      if (go) begin
        res_taken <= taken;
        res_target <= pc_e + W'(1) + (taken ? off_e : '0);
      end
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken <= '0;
      stat_not_taken <= '0;
    end else if (res_valid) begin
      if (res_taken && stat_taken != 8'hFF) stat_taken <= stat_taken + 8'd1;
      if (!res_taken && stat_not_taken != 8'hFF) stat_not_taken <= stat_not_taken + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and randomized checks of branch_resolve against a flag/pending model.
module tb_branch_resolve;
  import branch_pkg::*;
  logic clk = 0, rst_n = 0, cmp_issue = 0, flag_we = 0, sign_in = 0, z_in = 0, br_valid = 0;
  logic br_ready, res_valid, res_taken;
  logic [1:0] br_op = 0;
  logic [7:0] br_pc = 0, br_off = 0, res_target;
`ifdef BRANCH_STATS_EN
  logic [7:0] stat_taken, stat_not_taken;
`endif
  int passed = 0, total = 0;
  logic m_sign = 0, m_z = 0, m_pend = 0;

  branch_resolve dut (
    .clk(clk), .rst_n(rst_n), .cmp_issue(cmp_issue), .flag_we(flag_we),
    .sign_in(sign_in), .z_in(z_in), .br_valid(br_valid), .br_ready(br_ready),
    .br_op(br_op), .br_pc(br_pc), .br_off(br_off), .res_valid(res_valid),
    .res_taken(res_taken), .res_target(res_target)
`ifdef BRANCH_STATS_EN
    , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic cond(input int op, input logic s, input logic z);
    case (op)
      0: return z;
      1: return !z;
      2: return s;
      default: return !s;
    endcase
  endfunction

  task automatic set_flags(input logic s, input logic z, input logic issue);
    @(negedge clk);
    flag_we = 1; sign_in = s; z_in = z; cmp_issue = issue;
    @(negedge clk);
    flag_we = 0; cmp_issue = 0;
    m_sign = s; m_z = z; m_pend = issue;
  endtask

  task automatic issue_cmp();
    @(negedge clk);
    cmp_issue = 1;
    @(negedge clk);
    cmp_issue = 0;
    m_pend = 1;
  endtask

  task automatic run_br(input int op, input logic [7:0] pc, input logic [7:0] off,
                        input logic fwe_now, input logic s, input logic z,
                        input int wait_n, input logic issue_end);
    logic es, ez, tk;
    logic [7:0] tgt;
    @(negedge clk);
    check("ready_idle", br_ready, 1);
    br_valid = 1; br_op = 2'(op); br_pc = pc; br_off = off;
    if (fwe_now) begin flag_we = 1; sign_in = s; z_in = z; end
    if (!m_pend || fwe_now) begin
      es = fwe_now ? s : m_sign;
      ez = fwe_now ? z : m_z;
      if (fwe_now) begin m_sign = s; m_z = z; m_pend = 0; end
    end else begin
      repeat (wait_n) begin
        @(negedge clk);
        br_valid = 0;
        check("ready_wait", br_ready, 0);
        check("no_res_wait", res_valid, 0);
        cmp_issue = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      br_valid = 0;
      check("ready_wait_end", br_ready, 0);
      check("no_res_wait_end", res_valid, 0);
      flag_we = 1; sign_in = s; z_in = z; cmp_issue = issue_end;
      es = s; ez = z;
      m_sign = s; m_z = z; m_pend = issue_end;
    end
    tk = cond(op, es, ez);
    tgt = pc + 8'd1 + (tk ? off : 8'd0);
    @(negedge clk);
    br_valid = 0; flag_we = 0; cmp_issue = 0;
    check("res_valid", res_valid, 1);
    check("res_taken", res_taken, tk);
    check("res_target", res_target, tgt);
    check("ready_resolve", br_ready, 0);
    @(negedge clk);
    check("res_pulse", res_valid, 0);
    check("hold_taken", res_taken, tk);
    check("hold_target", res_target, tgt);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", br_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_taken", res_taken, 0);
    check("rst_target", res_target, 0);
`ifdef BRANCH_STATS_EN
    check("rst_stat_t", stat_taken, 0);
    check("rst_stat_nt", stat_not_taken, 0);
`endif
    rst_n = 1;
    run_br(0, 8'h30, 8'h04, 0, 0, 0, 0, 0);
    set_flags(0, 1, 0);
    run_br(0, 8'h10, 8'h05, 0, 0, 0, 0, 0);
    check("tp1_target", res_target, 8'h16);
    issue_cmp();
    run_br(2, 8'h20, 8'hFE, 0, 1, 0, 3, 0);
    check("tp2_target", res_target, 8'h1F);
    set_flags(0, 1, 0);
    issue_cmp();
    run_br(1, 8'h40, 8'h07, 1, 0, 0, 0, 0);
    check("tp3_target", res_target, 8'h48);
    set_flags(1, 0, 0);
    run_br(3, 8'hFF, 8'h10, 0, 0, 0, 0, 0);
    check("tp4_taken", res_taken, 0);
    check("tp4_target", res_target, 8'h00);
    issue_cmp();
    run_br(0, 8'h50, 8'h02, 0, 0, 1, 1, 1);
    run_br(1, 8'h60, 8'h03, 0, 1, 1, 0, 0);
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: set_flags(1'($urandom), 1'($urandom), 0);
        1: set_flags(1'($urandom), 1'($urandom), 1);
        2: issue_cmp();
        default: ;
      endcase
      run_br(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
             $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end
    set_flags(1, 1, 0);
    issue_cmp();
    @(negedge clk);
    br_valid = 1; br_op = 0; br_pc = 8'h70; br_off = 8'h01;
    @(negedge clk);
    br_valid = 0;
    check("wait_ready", br_ready, 0);
    rst_n = 0;
    #1;
    check("mid_rst_ready", br_ready, 1);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_taken", res_taken, 0);
    check("mid_rst_target", res_target, 0);
    @(negedge clk);
    rst_n = 1;
    flag_we = 1; sign_in = 1; z_in = 1;
    @(negedge clk);
    flag_we = 0;
    m_sign = 1; m_z = 1; m_pend = 0;
    repeat (3) begin
      check("post_rst_no_res", res_valid, 0);
      check("post_rst_ready", br_ready, 1);
      @(negedge clk);
    end
    run_br(0, 8'h80, 8'h10, 0, 0, 0, 0, 0);
    check("post_rst_taken", res_taken, 1);
`ifdef BRANCH_STATS_EN
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m_sign = 0; m_z = 0; m_pend = 0;
    for (int i = 0; i < 300; i++) run_br(0, 8'($urandom), 8'($urandom), 1, 0, 1, 0, 0);
    @(negedge clk);
    check("stat_taken_sat", stat_taken, 8'hFF);
    check("stat_not_taken", stat_not_taken, 8'h00);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Sequential condition-code register and branch resolver for the 8-bit datapath. It captures the `sign` and `z` flags produced by the compare stage and tracks whether a compare is still in flight. It accepts conditional-branch requests over a valid/ready handshake and returns a registered taken/not-taken decision with an 8-bit target. It sits between the compare-flag generator and the PC update logic.

## Interface
- `W`, 8, datapath and PC width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmp_issue`  in  1  a compare has been issued; flags become stale until `flag_we`.
- `flag_we`  in  1  compare result valid this cycle; latch `sign_in`, `z_in`.
- `sign_in`  in  1  signed less-than flag from the compare stage.
- `z_in`  in  1  zero flag from the compare stage.
- `br_valid`  in  1  branch request valid.
- `br_ready`  out  1  unit can accept a request.
- `br_op`  in  2  condition: 0 BEQ (z), 1 BNE (!z), 2 BLT (sign), 3 BGE (!sign).
- `br_pc`  in  W  PC of the branch instruction.
- `br_off`  in  W  two's-complement offset.
- `res_valid`  out  1  one-cycle pulse: result valid.
- `res_taken`  out  1  condition true.
- `res_target`  out  W  `br_pc + 1 + br_off` if taken, else `br_pc + 1`, modulo 2^W.

## Operation
- Flag register `{f_sign, f_z}` with `pending` bit.
- `cmp_issue` sets `pending`. `flag_we` loads the flags and clears `pending`.
- `cmp_issue` and `flag_we` in the same cycle: flags load and `pending` stays set, because the new compare is outstanding.
- FSM states:
  - IDLE: `br_ready`=1. On `br_valid`, capture op, pc and off. Go to RESOLVE if flags are usable this cycle, else WAIT.
  - WAIT: `br_ready`=0. On `flag_we`, go to RESOLVE using the incoming `sign_in`/`z_in`.
  - RESOLVE: evaluate, drive `res_valid`=1 for exactly one cycle, return to IDLE. `br_ready`=0.
- Flags are usable when `pending`=0, or when `flag_we`=1 in the same cycle (bypass: the incoming flags win over the stored ones).
- A `cmp_issue` arriving while in WAIT with no `flag_we` keeps the unit waiting.
- Arithmetic: all sums are W bits, carry discarded. Wrap-around is legal: pc=0xFF, off=0x00, taken gives 0x00.

## Timing
- Reset values: `f_sign`=0, `f_z`=0, `pending`=0, state IDLE, `br_ready`=1, `res_valid`=0, `res_taken`=0, `res_target`=0.
- Latency when flags are ready: request accepted in cycle N, result registered at cycle N+1 (`res_valid` high for cycle N+1). Next accept no earlier than N+2.
- Latency with flags pending: result one cycle after the `flag_we` cycle.
- `res_taken` and `res_target` hold their value until the next result.
- No backpressure on the result side. The consumer must take the result in the `res_valid` cycle.
- Reset asserted mid-operation (WAIT or RESOLVE) discards the captured request. No `res_valid` is produced.

## Configuration
- `BRANCH_STATS_EN` defined adds outputs `stat_taken` and `stat_not_taken` (8 bits each).
  - Each is a saturating counter incremented on every `res_valid` with the matching `res_taken`. They hold at 0xFF. Reset to 0.
- `BRANCH_STATS_EN` undefined: the ports and counters do not exist, and the rest of the behaviour is identical.

## Structure
- Shared package `branch_pkg`:
  - `br_op_t` enum: BEQ=0, BNE=1, BLT=2, BGE=3.
  - `br_state_t` enum: IDLE, WAIT, RESOLVE.
  - Constant `BR_W`=8.
- One sub-module, `br_cond_eval`: combinational, takes op, sign and z, returns taken. It is reused by the decode-stage predictor.

## Test plan
- Flags z=1 latched, `pending`=0. BEQ pc=0x10, off=0x05 → next cycle `res_valid`=1, taken=1, target=0x16.
- `cmp_issue`, then BLT pc=0x20, off=0xFE issued. Hold for 3 cycles, then `flag_we` with sign=1 → `br_ready`=0 throughout. Result one cycle after `flag_we`: taken=1, target=0x1F.
- `br_valid` and `flag_we` (z=0) in the same cycle, with stale stored z=1, BNE pc=0x40 → taken=1, target=0x41+off (bypass honoured).
- BGE with sign=1, pc=0xFF, off=0x10 → taken=0, target=0x00 (wrap).
- `rst_n` low during WAIT → all outputs return to reset values. No `res_valid` after release. `br_ready`=1.
- With `BRANCH_STATS_EN`: 300 taken branches → `stat_taken`=0xFF, `stat_not_taken`=0.
